// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT frame sequencer.
package fft_pkg;
  localparam int DEF_FFT_POINTS  = 1024;
  localparam int DEF_LOG2_POINTS = 10;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_FFTPTS_W    = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT_OUT
  } seq_state_e;
endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Audio-in, FFT sink/source and status signals of the frame sequencer.
interface fft_frame_sequencer_if
  import fft_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FFTPTS_W = DEF_FFTPTS_W
);
  logic [DATA_W-1:0]   sample_in;
  logic                sample_valid;
  logic                sink_valid;
  logic                sink_ready;
  logic                sink_sop;
  logic                sink_eop;
  logic [DATA_W-1:0]   sink_real;
  logic [DATA_W-1:0]   sink_imag;
  logic [FFTPTS_W-1:0] fft_pts;
  logic                inverse;
  logic                source_valid;
  logic                source_eop;
  logic                source_ready;
  logic                frame_done;
  logic                overflow;
  logic                busy;

  modport master (
    input  sample_in, sample_valid, sink_ready, source_valid, source_eop,
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fft_pts,
           inverse, source_ready, frame_done, overflow, busy
  );

  modport slave (
    output sample_in, sample_valid, sink_ready, source_valid, source_eop,
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fft_pts,
           inverse, source_ready, frame_done, overflow, busy
  );
endinterface

// File: rtl/frame_bank_ram.sv
// Ping-pong frame storage: one write port, one read port with registered output.
module frame_bank_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: no reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fft_frame_sequencer.sv
// Collects samples into ping-pong banks and plays each full bank into the FFT
// sink as one packet, keeping a single frame in flight through the core.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int FFT_POINTS  = DEF_FFT_POINTS,
  parameter int LOG2_POINTS = DEF_LOG2_POINTS,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FFTPTS_W    = DEF_FFTPTS_W
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_frame_sequencer_if.master bus
);
  localparam logic [LOG2_POINTS-1:0] LAST_IDX = LOG2_POINTS'(FFT_POINTS - 1);

  seq_state_e             state_q, state_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [LOG2_POINTS-1:0] rd_idx_q, rd_idx_d;
  logic                   frame_done_q, frame_done_d;
  logic                   source_ready_q;
  logic [1:0]             full_q, full_d;
  logic                   wr_bank_q, wr_bank_d;
  logic [LOG2_POINTS-1:0] wr_idx_q, wr_idx_d;
  logic                   overflow_q, overflow_d;
  logic                   ram_we;
  logic [DATA_W-1:0]      ram_rdata;
  logic                   sink_valid, sink_sop, sink_eop, busy;
  logic                   xfer, eop_xfer;

  // Write side: the full check sees the flag after this cycle's release.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path infers a latch.
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    overflow_d = overflow_q;
    ram_we     = 1'b0;
    if (eop_xfer) full_d[rd_bank_q] = 1'b0;
    if (bus.sample_valid) begin
      if (full_d[wr_bank_q]) begin
        overflow_d = 1'b1;
      end else begin
        ram_we   = 1'b1;
        wr_idx_d = wr_idx_q + 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rd_bank_q      <= 1'b0;
      rd_idx_q       <= '0;
      frame_done_q   <= 1'b0;
      source_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_bank_q      <= rd_bank_d;
      rd_idx_q       <= rd_idx_d;
      frame_done_q   <= frame_done_d;
      source_ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rd_idx_d = '0;
        if (full_q[rd_bank_q]) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (xfer) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            rd_bank_d = ~rd_bank_q;
            state_d   = ST_WAIT_OUT;
          end
        end
      end
      ST_WAIT_OUT: begin
        if (bus.source_valid && bus.source_eop) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sink_valid = (state_q == ST_STREAM);
    sink_sop   = sink_valid && (rd_idx_q == '0);
    sink_eop   = sink_valid && (rd_idx_q == LAST_IDX);
    busy       = (state_q != ST_IDLE);
  end

  assign xfer     = sink_valid && bus.sink_ready;
  assign eop_xfer = xfer && (rd_idx_q == LAST_IDX);

  // The read register is the prefetch stage: its address already points at
  // the beat that will be on the bus next cycle, so a stall simply re-reads.
  frame_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2_POINTS + 1)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i ({wr_bank_q, wr_idx_q}),
    .wdata_i (bus.sample_in),
    .raddr_i ({rd_bank_q, rd_idx_d}),
    .rdata_o (ram_rdata)
  );

  assign bus.sink_valid   = sink_valid;
  assign bus.sink_sop     = sink_sop;
  assign bus.sink_eop     = sink_eop;
  assign bus.sink_real    = sink_valid ? ram_rdata : '0;
  assign bus.sink_imag    = '0;
  assign bus.fft_pts      = FFTPTS_W'(FFT_POINTS);
  assign bus.inverse      = 1'b0;
  assign bus.source_ready = source_ready_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.overflow     = overflow_q;
  assign bus.busy         = busy;
endmodule
